// File: rtl/cr16_muldiv.sv
// Iterative multiply/divide unit: shift-add MUL/MULH and restoring DIV/REM, one bit per cycle.
// Optional signed support is compiled in with the CR16_MULDIV_SIGNED_EN macro.
module cr16_muldiv #(
    parameter int P_WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_VALID,
    input  logic [1:0]         I_OPCODE,
    input  logic               I_SIGNED,
    input  logic [P_WIDTH-1:0] I_A,
    input  logic [P_WIDTH-1:0] I_B,
    output logic               O_READY,
    output logic               O_VALID,
    input  logic               I_ACK,
    output logic [P_WIDTH-1:0] O_C,
    output logic [4:0]         O_STATUS
);
    localparam int W  = P_WIDTH;
    localparam int CW = $clog2(P_WIDTH);
    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic [4:0]     status_q, status_d;

    logic           sgn_q, nres_q, nrem_q, in_sgn, div_ovf;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum, div_shift;
    logic           div_ge;
    logic [W-1:0]   div_sub;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;

`ifdef CR16_MULDIV_SIGNED_EN
    logic sgn_d, nres_d, nrem_d, a_neg, b_neg;

    assign in_sgn  = I_SIGNED;
    assign a_neg   = I_SIGNED & I_A[W-1];
    assign b_neg   = I_SIGNED & I_B[W-1];
    assign a_mag   = a_neg ? -I_A : I_A;
    assign b_mag   = b_neg ? -I_B : I_B;
    assign div_ovf = I_SIGNED && (I_A == MIN_NEG) && (I_B == '1);

    always_comb begin
        sgn_d  = sgn_q;
        nres_d = nres_q;
        nrem_d = nrem_q;
        if (state_q == IDLE && I_VALID) begin
            sgn_d  = I_SIGNED;
            nres_d = a_neg ^ b_neg;
            nrem_d = a_neg;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sgn_q  <= 1'b0;
            nres_q <= 1'b0;
            nrem_q <= 1'b0;
        end else begin
            sgn_q  <= sgn_d;
            nres_q <= nres_d;
            nrem_q <= nrem_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = I_SIGNED;
    assign in_sgn  = 1'b0;
    assign sgn_q   = 1'b0;
    assign nres_q  = 1'b0;
    assign nrem_q  = 1'b0;
    assign a_mag   = I_A;
    assign b_mag   = I_B;
    assign div_ovf = 1'b0;
`endif

    function automatic logic [4:0] mk_status(input logic [W-1:0] c, input logic carry,
                                             input logic flag, input logic sgn);
        return {sgn & c[W-1], (c == '0), flag, 1'b0, carry};
    endfunction

    // lo holds the multiplier (product bits shift in from the top) or the dividend/quotient
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[W-1:0] - b_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        prod     = '0;
        quo      = '0;
        rem      = '0;
        case (state_q)
            IDLE: begin
                if (I_VALID) begin
                    op_d  = I_OPCODE;
                    cnt_d = '0;
                    hi_d  = '0;
                    lo_d  = a_mag;
                    b_d   = b_mag;
                    if (I_OPCODE[1] && (I_B == '0)) begin
                        state_d  = DONE;
                        c_d      = (I_OPCODE == OP_DIV) ? '1 : I_A;
                        status_d = mk_status(c_d, 1'b0, 1'b1, in_sgn);
                    end else if (I_OPCODE[1] && div_ovf) begin
                        state_d  = DONE;
                        c_d      = (I_OPCODE == OP_DIV) ? MIN_NEG : '0;
                        status_d = mk_status(c_d, 1'b0, 1'b1, in_sgn);
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q[1]) begin
                    hi_d = mul_sum[W:1];
                    lo_d = {mul_sum[0], lo_q[W-1:1]};
                end else if (div_ge) begin
                    hi_d = div_sub;
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[W-1:0];
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    prod    = nres_q ? -{hi_d, lo_d} : {hi_d, lo_d};
                    quo     = nres_q ? -lo_d : lo_d;
                    rem     = nrem_q ? -hi_d : hi_d;
                    case (op_q)
                        OP_MUL:  c_d = prod[W-1:0];
                        OP_MULH: c_d = prod[2*W-1:W];
                        OP_DIV:  c_d = quo;
                        default: c_d = rem;
                    endcase
                    status_d = mk_status(c_d, (op_q == OP_MUL) && (prod[2*W-1:W] != '0),
                                         1'b0, sgn_q);
                end
            end
            DONE: begin
                if (I_ACK) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    assign O_READY  = (state_q == IDLE);
    assign O_VALID  = (state_q == DONE);
    assign O_C      = c_q;
    assign O_STATUS = status_q;

endmodule

// File: tb/tb_cr16_muldiv.sv
// Self-checking bench for cr16_muldiv (P_WIDTH=16) with a scoreboard of expected results.
module tb_cr16_muldiv;
    logic        clk = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_VALID = 1'b0;
    logic [1:0]  I_OPCODE = 2'd0;
    logic        I_SIGNED = 1'b0;
    logic [15:0] I_A = '0;
    logic [15:0] I_B = '0;
    logic        I_ACK = 1'b0;
    logic        O_READY, O_VALID;
    logic [15:0] O_C;
    logic [4:0]  O_STATUS;

    typedef struct {
        logic [15:0] c;
        logic [4:0]  st;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cr16_muldiv #(.P_WIDTH(16)) dut (
        .I_CLK(clk), .I_RESET(I_RESET), .I_VALID(I_VALID), .I_OPCODE(I_OPCODE),
        .I_SIGNED(I_SIGNED), .I_A(I_A), .I_B(I_B), .O_READY(O_READY), .O_VALID(O_VALID),
        .I_ACK(I_ACK), .O_C(O_C), .O_STATUS(O_STATUS)
    );

    always #5 clk = ~clk;

    // Reference model: 32-bit product, truncating division, flags derived from the result.
    task automatic model(input logic [1:0] op, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] c, output logic [4:0] st,
                         output int lat);
        logic [31:0] p;
        logic carry, flag, neg_en;
        int sa, sbv;
        carry = 1'b0; flag = 1'b0; neg_en = 1'b0; lat = 17;
        sa = int'($signed(a)); sbv = int'($signed(b));
        p = 32'(a) * 32'(b);
`ifdef CR16_MULDIV_SIGNED_EN
        neg_en = sg;
        if (sg) p = 32'(sa * sbv);
`else
        if (sg) neg_en = 1'b0;
`endif
        case (op)
            2'd0: begin c = p[15:0]; carry = (p[31:16] != 16'h0); end
            2'd1: c = p[31:16];
            default: begin
                if (b == 16'h0) begin
                    c = (op == 2'd2) ? 16'hFFFF : a; flag = 1'b1; lat = 1;
                end else if (neg_en && a == 16'h8000 && b == 16'hFFFF) begin
                    c = (op == 2'd2) ? 16'h8000 : 16'h0000; flag = 1'b1; lat = 1;
                end else if (neg_en) begin
                    c = (op == 2'd2) ? 16'(sa / sbv) : 16'(sa % sbv);
                end else begin
                    c = (op == 2'd2) ? a / b : a % b;
                end
            end
        endcase
        st = {neg_en & c[15], (c == 16'h0), flag, 1'b0, carry};
    endtask

    task automatic pulse_reset();
        I_RESET = 1'b1;
        @(negedge clk);
        I_RESET = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ec, input logic [4:0] est,
                         input int elat, input logic early_ack);
        exp_t e;
        int lat;
        e.c = ec; e.st = est; e.lat = elat;
        exp_q.push_back(e);
        @(negedge clk);
        checks++;
        if (O_READY !== 1'b1) begin
            errors++; $display("FAIL ready_before_accept got=%b want=1", O_READY);
        end
        I_VALID = 1'b1; I_OPCODE = op; I_SIGNED = sg; I_A = a; I_B = b;
        @(negedge clk);
        I_VALID = 1'b0; I_A = 16'($urandom); I_B = 16'($urandom); I_ACK = early_ack;
        lat = 1;
        while (O_VALID !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (O_VALID !== 1'b1) begin
            errors++;
            $display("FAIL valid_timeout op=%0d a=%h b=%h got=no_valid want=valid", op, a, b);
            I_ACK = 1'b0;
            pulse_reset();
            return;
        end
        $display("op=%0d sgn=%b a=%h b=%h c=%h st=%b lat=%0d", op, sg, a, b, O_C, O_STATUS, lat);
        checks++;
        if (O_C !== e.c) begin
            errors++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", op, a, b, O_C, e.c);
        end
        checks++;
        if (O_STATUS !== e.st) begin
            errors++; $display("FAIL status op=%0d a=%h b=%h got=%b want=%b", op, a, b, O_STATUS, e.st);
        end
        checks++;
        if (lat !== e.lat) begin
            errors++; $display("FAIL latency op=%0d got=%0d want=%0d", op, lat, e.lat);
        end
        I_ACK = 1'b1;
        @(negedge clk);
        I_ACK = 1'b0;
        checks++;
        if (O_VALID !== 1'b0 || O_READY !== 1'b1) begin
            errors++; $display("FAIL idle_after_ack got=v%b r%b want=v0 r1", O_VALID, O_READY);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({O_READY, O_VALID, O_C, O_STATUS} !== {1'b1, 1'b0, 16'h0, 5'h0}) begin
            errors++;
            $display("FAIL reset_state got=r%b v%b c=%h st=%b want=r1 v0 c=0000 st=00000",
                     O_READY, O_VALID, O_C, O_STATUS);
        end
        I_RESET = 1'b0;
    endtask

    task automatic test_mul();
        do_op(2'd0, 1'b0, 16'd300, 16'd200, 16'hEA60, 5'b00000, 17, 1'b0);
        do_op(2'd1, 1'b0, 16'h1234, 16'h5678, 16'h0626, 5'b00000, 17, 1'b0);
        do_op(2'd0, 1'b0, 16'h1234, 16'h5678, 16'h0060, 5'b00001, 17, 1'b0);
        do_op(2'd0, 1'b0, 16'h0000, 16'h0005, 16'h0000, 5'b01000, 17, 1'b0);
    endtask

    task automatic test_div();
        do_op(2'd2, 1'b0, 16'd1000, 16'd7, 16'h008E, 5'b00000, 17, 1'b0);
        do_op(2'd3, 1'b0, 16'd1000, 16'd7, 16'h0006, 5'b00000, 17, 1'b0);
        do_op(2'd2, 1'b0, 16'd5, 16'd7, 16'h0000, 5'b01000, 17, 1'b0);
        do_op(2'd3, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b01000, 17, 1'b0);
    endtask

    task automatic test_div_zero();
        do_op(2'd2, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 5'b00100, 1, 1'b0);
        do_op(2'd3, 1'b0, 16'h1234, 16'h0000, 16'h1234, 5'b00100, 1, 1'b0);
    endtask

    task automatic test_signed();
`ifdef CR16_MULDIV_SIGNED_EN
        do_op(2'd2, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 5'b10000, 17, 1'b0);
        do_op(2'd3, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 5'b10000, 17, 1'b0);
        do_op(2'd2, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 5'b10100, 1, 1'b0);
        do_op(2'd3, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 5'b01100, 1, 1'b0);
        do_op(2'd1, 1'b1, 16'hFFFF, 16'h0003, 16'hFFFF, 5'b10000, 17, 1'b0);
`else
        do_op(2'd2, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 5'b00000, 17, 1'b0);
        do_op(2'd1, 1'b1, 16'hFFFF, 16'h0003, 16'h0002, 5'b00000, 17, 1'b0);
`endif
    endtask

    task automatic test_ack_hold();
        exp_t e;
        int   lat;
        e.c = 16'hEA60; e.st = 5'b00000; e.lat = 17;
        exp_q.push_back(e);
        @(negedge clk);
        I_VALID = 1'b1; I_OPCODE = 2'd0; I_SIGNED = 1'b0; I_A = 16'd300; I_B = 16'd200;
        @(negedge clk);
        I_VALID = 1'b0;
        lat = 1;
        while (O_VALID !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (O_C !== e.c || O_VALID !== 1'b1) begin
            errors++; $display("FAIL hold_first got=%h v%b want=%h v1", O_C, O_VALID, e.c);
        end
        for (int i = 0; i < 5; i++) begin
            I_VALID = 1'b1; I_OPCODE = 2'd2; I_A = 16'd9; I_B = 16'd0;
            @(negedge clk);
            checks++;
            if (O_C !== e.c || O_READY !== 1'b0 || O_VALID !== 1'b1 || O_STATUS !== e.st) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got=%h r%b v%b want=%h r0 v1", i, O_C,
                         O_READY, O_VALID, e.c);
            end
        end
        $display("ack_hold c=%h held 5 cycles", O_C);
        I_VALID = 1'b0; I_ACK = 1'b1;
        @(negedge clk);
        I_ACK = 1'b0;
        checks++;
        if (O_READY !== 1'b1 || O_VALID !== 1'b0) begin
            errors++; $display("FAIL hold_release got=r%b v%b want=r1 v0", O_READY, O_VALID);
        end
        @(negedge clk);
        checks++;
        if (O_VALID !== 1'b0) begin
            errors++; $display("FAIL hold_ignored_req got=v%b want=v0", O_VALID);
        end
    endtask

    task automatic test_reset_midbusy();
        @(negedge clk);
        I_VALID = 1'b1; I_OPCODE = 2'd0; I_SIGNED = 1'b0; I_A = 16'hFFFF; I_B = 16'hFFFF;
        @(negedge clk);
        I_VALID = 1'b0;
        repeat (7) @(negedge clk);
        pulse_reset();
        checks++;
        if ({O_READY, O_VALID, O_C, O_STATUS} !== {1'b1, 1'b0, 16'h0, 5'h0}) begin
            errors++;
            $display("FAIL midbusy_reset got=r%b v%b c=%h st=%b want=r1 v0 c=0000 st=00000",
                     O_READY, O_VALID, O_C, O_STATUS);
        end
        $display("reset at busy cycle 8 c=%h st=%b", O_C, O_STATUS);
        do_op(2'd0, 1'b0, 16'd3, 16'd4, 16'h000C, 5'b00000, 17, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic        sg;
        logic [15:0] a, b, c;
        logic [4:0]  st;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            if (i % 6 == 5) b = 16'h0001;
            model(op, sg, a, b, c, st, lat);
            do_op(op, sg, a, b, c, st, lat, 1'(i % 2));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_signed();
        test_ack_hold();
        test_reset_midbusy();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
